cmp_tally: RTL
==============

# cmp_tally

Downstream consumer of the 2-bit magnitude comparator. Accepts one comparator result per valid cycle (X = A>B, Y = A==B, Z = A<B) and tallies greater/equal/less outcomes over a fixed window of WIN_LEN samples. At the end of each window it presents the three counts plus a verdict through a valid/ready handshake. It back-pressures the comparator while the result is pending.

## Interface
- WIN_LEN, 16: samples per window; legal range 1 to 2^CNT_W-1.
- CNT_W, 8: width of each tally output.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  comparator result present this cycle.
- in_ready  out  1  block accepts a sample; a sample is accepted when in_valid && in_ready at the edge.
- X  in  1  comparator A>B.
- Y  in  1  comparator A==B.
- Z  in  1  comparator A<B.
- res_valid  out  1  window result held on outputs.
- res_ready  in  1  consumer takes the result.
- gt_cnt, eq_cnt, lt_cnt  out  CNT_W  tallies for the completed window.
- err_cnt  out  CNT_W  non-one-hot samples in the window (see Configuration).
- verdict  out  2  2'b01 GT, 2'b10 LT, 2'b00 EQ.

## Operation
- The FSM has two states, ACCUM and HOLD. Reset enters ACCUM.
- ACCUM:
  - in_ready=1.
  - Each accepted sample increments exactly one of gt/eq/lt (or err) and increments sample counter smp_cnt (width clog2(WIN_LEN+1)).
  - When the accepted sample makes smp_cnt reach WIN_LEN, the tallies (including that sample) are registered into the output registers, smp_cnt and the working tallies are cleared, and the FSM moves to HOLD.
- HOLD:
  - in_ready=0 and res_valid=1.
  - Outputs stay stable until res_ready=1 at an edge. That edge sets res_valid=0 and returns the FSM to ACCUM.
- Verdict is computed at latch time:
  - GT if gt>lt.
  - LT if lt>gt.
  - Otherwise EQ. eq_cnt and err_cnt do not affect the verdict.
- Tallies never wrap: WIN_LEN ≤ 2^CNT_W-1 guarantees this. Violating that range is a configuration error, not handled at runtime.
- in_valid=0 cycles are ignored; window length counts accepted samples, not cycles.
- X/Y/Z are don't-care when in_valid=0 or in_ready=0.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 on the first cycle after. res_valid=0, all counts=0, verdict=2'b00, smp_cnt=0.
- Latency: res_valid rises the cycle after the edge that accepted the WIN_LEN-th sample.
- Minimum window period is WIN_LEN+1 cycles: WIN_LEN accept cycles plus one HOLD cycle when res_ready is held high.
- res_ready is sampled only in HOLD. res_ready=1 in ACCUM has no effect.
- rst during HOLD drops a pending result. rst during ACCUM discards the partial window. In both cases the next cycle is in the reset state.
- WIN_LEN=1: every accepted sample produces a result, so at most one sample every 2 cycles.

## Configuration
- Macro: CMP_TALLY_ONEHOT_CHECK_EN.
- Defined:
  - A sample whose {X,Y,Z} is not one-hot increments err_cnt only. It still counts toward WIN_LEN.
- Undefined:
  - Samples are classified by priority X > Y > Z. An all-zero sample counts as eq.
  - err_cnt is tied to 0 and no error logic is synthesized.

## Structure
- Package cmp_tally_pkg holds:
  - State encoding localparams ST_ACCUM and ST_HOLD.
  - Verdict constants VERD_EQ=2'b00, VERD_GT=2'b01, VERD_LT=2'b10.
- One sub-module, cmp_tally_class:
  - Combinational decode of {X,Y,Z} into one-hot increment enables inc_gt/inc_eq/inc_lt/inc_err.
  - The macro applies here only.
- Top level holds the FSM, counters and output registers.

## Test plan
- WIN_LEN=4, CNT_W=8, res_ready=1: feed X,X,Y,Z on 4 consecutive cycles -> res_valid one cycle later; gt=2, eq=1, lt=1, verdict=2'b01; in_ready low exactly 1 cycle.
- Feed Z,Z,Z,X with res_ready=0 for 5 cycles -> outputs stable at lt=3, gt=1, verdict=2'b10; in_ready=0 throughout; result clears on the first res_ready=1 edge.
- Feed Y,Y,Y,Y interleaved with in_valid=0 gaps -> eq=4, verdict=2'b00; gaps do not advance the window.
- With macro defined, feed {X,Y,Z}=110, X, 000, Z -> err=2, gt=1, lt=1, verdict=2'b00. Without macro, same stimulus -> gt=2, eq=1, lt=1, err=0.
- Assert rst after 3 accepted samples, then feed 4 Z -> lt=4, gt=eq=0; no stale counts carried over.
- WIN_LEN=1: in_valid held high with X -> res_valid every other cycle, gt=1 each time.

Source files
------------

// File: rtl/cmp_tally_pkg.sv
// cmp_tally_pkg: shared constants and types for the comparator tally block.
//   ST_ACCUM / ST_HOLD : FSM state encodings
//   VERD_*             : verdict output codes
//   verdict_f          : verdict from the greater/less tallies
package cmp_tally_pkg;

   // FSM state encodings
   localparam logic ST_ACCUM = 1'b0;
   localparam logic ST_HOLD  = 1'b1;

   typedef enum logic {
      S_ACCUM = ST_ACCUM,
      S_HOLD  = ST_HOLD
   } state_t;

   // Verdict codes presented on the verdict output
   localparam logic [1:0] VERD_EQ = 2'b00;
   localparam logic [1:0] VERD_GT = 2'b01;
   localparam logic [1:0] VERD_LT = 2'b10;

   // Verdict depends only on gt vs lt; ties (including 0/0) report EQ
   function automatic logic [1:0] verdict_f(input logic [31:0] gt, input logic [31:0] lt);
      logic [1:0] v;
      v = VERD_EQ;
      if (gt > lt) begin
         v = VERD_GT;
      end else if (lt > gt) begin
         v = VERD_LT;
      end
      return v;
   endfunction

endpackage

// File: rtl/cmp_tally_class.sv
// cmp_tally_class: combinational decode of one comparator result into
// exactly one increment enable.
// Optional feature macro: CMP_TALLY_ONEHOT_CHECK_EN
//   defined   : only one-hot {X,Y,Z} counts as gt/eq/lt, anything else is an error
//   undefined : priority X > Y > Z, all-zero counts as eq, no error output
// Ports:
//   i_x, i_y, i_z   comparator A>B, A==B, A<B
//   o_inc_gt_c      increment greater tally
//   o_inc_eq_c      increment equal tally
//   o_inc_lt_c      increment less tally
//   o_inc_err_c     increment error tally (always 0 without the check)
module cmp_tally_class
   import cmp_tally_pkg::*;
(
   input  logic i_x,
   input  logic i_y,
   input  logic i_z,
   output logic o_inc_gt_c,
   output logic o_inc_eq_c,
   output logic o_inc_lt_c,
   output logic o_inc_err_c
);

`ifdef CMP_TALLY_ONEHOT_CHECK_EN
   // Strict one-hot decode; every other pattern is flagged
   always_comb begin
      o_inc_gt_c  = 1'b0;
      o_inc_eq_c  = 1'b0;
      o_inc_lt_c  = 1'b0;
      o_inc_err_c = 1'b0;
      case ({i_x, i_y, i_z})
         3'b100:  o_inc_gt_c  = 1'b1;
         3'b010:  o_inc_eq_c  = 1'b1;
         3'b001:  o_inc_lt_c  = 1'b1;
         default: o_inc_err_c = 1'b1;
      endcase
   end
`else
   // Priority decode; an all-zero sample falls through to eq
   always_comb begin
      o_inc_gt_c  = i_x;
      o_inc_eq_c  = !i_x && (i_y || !i_z);
      o_inc_lt_c  = !i_x && !i_y && i_z;
      o_inc_err_c = 1'b0;
   end
`endif

endmodule

// File: rtl/cmp_tally.sv
// cmp_tally: tallies comparator results (gt/eq/lt) over windows of WIN_LEN
// accepted samples and presents each window's counts plus a verdict through
// a valid/ready handshake, stalling the comparator while a result is pending.
// Optional feature macro: CMP_TALLY_ONEHOT_CHECK_EN (see cmp_tally_class).
// Parameters:
//   WIN_LEN   samples per window, 1 .. 2**CNT_W-1
//   CNT_W     width of each tally output
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready sample handshake; accept when both high at the edge
//   X, Y, Z           comparator A>B, A==B, A<B
//   res_valid/res_ready result handshake
//   gt_cnt, eq_cnt, lt_cnt, err_cnt  completed-window tallies
//   verdict           2'b01 GT, 2'b10 LT, 2'b00 EQ
module cmp_tally
   import cmp_tally_pkg::*;
#(
   parameter int unsigned WIN_LEN = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             X,
   input  logic             Y,
   input  logic             Z,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       verdict
);

   localparam int unsigned SMP_W = $clog2(WIN_LEN + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;
   logic             r_res_valid;
   logic             w_in_ready_nxt;
   logic             w_res_valid_nxt;

   logic [SMP_W-1:0] r_smp_cnt;
   logic [CNT_W-1:0] r_gt;
   logic [CNT_W-1:0] r_eq;
   logic [CNT_W-1:0] r_lt;
   logic [CNT_W-1:0] r_err;

   logic [CNT_W-1:0] r_gt_out;
   logic [CNT_W-1:0] r_eq_out;
   logic [CNT_W-1:0] r_lt_out;
   logic [CNT_W-1:0] r_err_out;
   logic [1:0]       r_verdict;

   logic             w_inc_gt;
   logic             w_inc_eq;
   logic             w_inc_lt;
   logic             w_inc_err;
   logic             w_accept;
   logic             w_last;
   logic             w_latch;
   logic [CNT_W-1:0] w_gt_nxt;
   logic [CNT_W-1:0] w_eq_nxt;
   logic [CNT_W-1:0] w_lt_nxt;
   logic [CNT_W-1:0] w_err_nxt;

   // Sample classification
   cmp_tally_class u_class (
      .i_x         (X),
      .i_y         (Y),
      .i_z         (Z),
      .o_inc_gt_c  (w_inc_gt),
      .o_inc_eq_c  (w_inc_eq),
      .o_inc_lt_c  (w_inc_lt),
      .o_inc_err_c (w_inc_err)
   );

   // in_ready is registered and only high in ACCUM, so it gates acceptance
   assign w_accept = in_valid && r_in_ready;
   assign w_last   = w_accept && (r_smp_cnt == SMP_W'(WIN_LEN - 1));

   // Tallies including the current sample; used both to accumulate and latch
   assign w_gt_nxt  = r_gt  + CNT_W'(w_accept && w_inc_gt);
   assign w_eq_nxt  = r_eq  + CNT_W'(w_accept && w_inc_eq);
   assign w_lt_nxt  = r_lt  + CNT_W'(w_accept && w_inc_lt);
   assign w_err_nxt = r_err + CNT_W'(w_accept && w_inc_err);

   // FSM state register plus the registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_ACCUM;
         r_in_ready  <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_res_valid <= w_res_valid_nxt;
      end
   end

   // Next state and next handshake outputs
   always_comb begin
      w_state_nxt     = r_state;
      w_latch         = 1'b0;
      w_in_ready_nxt  = 1'b0;
      w_res_valid_nxt = 1'b0;
      case (r_state)
         S_ACCUM: begin
            if (w_last) begin
               w_state_nxt = S_HOLD;
               w_latch     = 1'b1;
            end
         end
         S_HOLD: begin
            if (res_ready) begin
               w_state_nxt = S_ACCUM;
            end
         end
         default: w_state_nxt = S_ACCUM;
      endcase
      w_in_ready_nxt  = (w_state_nxt == S_ACCUM);
      w_res_valid_nxt = (w_state_nxt == S_HOLD);
   end

   // Working tallies and sample counter; cleared when a window completes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_smp_cnt <= '0;
         r_gt      <= '0;
         r_eq      <= '0;
         r_lt      <= '0;
         r_err     <= '0;
      end else if (w_latch) begin
         r_smp_cnt <= '0;
         r_gt      <= '0;
         r_eq      <= '0;
         r_lt      <= '0;
         r_err     <= '0;
      end else if (w_accept) begin
         r_smp_cnt <= r_smp_cnt + SMP_W'(1);
         r_gt      <= w_gt_nxt;
         r_eq      <= w_eq_nxt;
         r_lt      <= w_lt_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // Result registers; loaded only at window completion, held through HOLD
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gt_out  <= '0;
         r_eq_out  <= '0;
         r_lt_out  <= '0;
         r_err_out <= '0;
         r_verdict <= VERD_EQ;
      end else if (w_latch) begin
         r_gt_out  <= w_gt_nxt;
         r_eq_out  <= w_eq_nxt;
         r_lt_out  <= w_lt_nxt;
         r_err_out <= w_err_nxt;
         r_verdict <= verdict_f(32'(w_gt_nxt), 32'(w_lt_nxt));
      end
   end

   assign in_ready  = r_in_ready;
   assign res_valid = r_res_valid;
   assign gt_cnt    = r_gt_out;
   assign eq_cnt    = r_eq_out;
   assign lt_cnt    = r_lt_out;
   assign err_cnt   = r_err_out;
   assign verdict   = r_verdict;

endmodule
